// File: rtl/reg8_share_ctrl.sv
// reg8_share_ctrl: round-robin arbiter giving four requesters
// serialized read/write access to one shared register.
module reg8_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*WIDTH-1:0]  wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [WIDTH-1:0]       rdata,
    output logic                   reg_en,
    output logic [WIDTH-1:0]       reg_in,
    input  logic [WIDTH-1:0]       reg_out
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q, win_q, win_d, idx;
    logic [WIDTH-1:0] wd_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign wd_a[i] = wdata[i*WIDTH +: WIDTH];
    end

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        win_d = ptr_q;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (req[idx]) win_d = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            reg_en  <= 1'b0;
            reg_in  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        win_q   <= win_d;
                        gnt     <= NREQ'(1) << win_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[win_q]) begin
                        gnt     <= '0;
                        state_q <= IDLE;
                    end else begin
                        reg_en  <= we[win_q];
                        reg_in  <= we[win_q] ? wd_a[win_q] : reg_in;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    reg_en  <= 1'b0;
                    gnt     <= '0;
                    done    <= NREQ'(1) << win_q;
                    state_q <= DONE;
                end
                DONE: begin
                    done    <= '0;
                    rdata   <= reg_out;
                    ptr_q   <= PW'((int'(win_q) + 1) % NREQ);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg8_share_ctrl.sv
// tb_reg8_share_ctrl: directed and randomized transactions against a
// transaction-level model of arbitration and the shared register.
module tb_reg8_share_ctrl;
    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  we = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt, done;
    logic [7:0]  rdata, reg_in, reg_out;
    logic        reg_en;
    logic [7:0]  shreg = '0;
    logic [3:0]  pg = '0;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;
    logic [7:0] reg_m = '0;
    logic [7:0] rin_m = '0;

    reg8_share_ctrl #(.WIDTH(8), .NREQ(4)) dut (
        .clk(clk), .res(res), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .reg_en(reg_en),
        .reg_in(reg_in), .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    // The shared register the controller drives.
    always @(posedge clk) if (reg_en) shreg <= reg_in;
    assign reg_out = shreg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!res) begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            chk("done_onehot", 32'($onehot0(done)), 1);
            chk("gnt_done_excl", 32'(|gnt && |done), 0);
            chk("en_only_xfer", 32'(reg_en && !(gnt != 0 && gnt == pg)), 0);
            chk("done_after_gnt", 32'(|done && pg != done), 0);
        end
        pg <= gnt;
    end

    task automatic do_reset();
        res = 1'b1;
        req = '0;
        @(posedge clk); #1;
        res = 1'b0;
        ptr_m = 0;
        rin_m = '0;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_en", reg_en, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_regin", reg_in, 0);
    endtask

    // One arbitration starting in IDLE; ab withdraws the winner during GRANT,
    // jit scrambles other requests mid-transaction.
    task automatic txn(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d,
                       input bit ab, input bit jit);
        int wn;
        wn = pick(r, ptr_m);
        req = r;
        we = w;
        wdata = d;
        @(posedge clk); #1;
        if (wn < 0) begin
            chk("idle_gnt", gnt, 0);
            return;
        end
        chk("grant1_gnt", gnt, 32'(1) << wn);
        chk("grant1_en", reg_en, 0);
        if (jit) req = 4'($urandom);
        req[wn] = !ab;
        @(posedge clk); #1;
        if (ab) begin
            chk("abort_gnt", gnt, 0);
            chk("abort_en", reg_en, 0);
            chk("abort_done", done, 0);
            return;
        end
        chk("xfer_gnt", gnt, 32'(1) << wn);
        chk("xfer_en", reg_en, w[wn]);
        if (w[wn]) begin
            rin_m = d[wn*8 +: 8];
            reg_m = rin_m;
        end
        chk("xfer_regin", reg_in, rin_m);
        if (jit) req = 4'($urandom);
        @(posedge clk); #1;
        chk("done_gnt", gnt, 0);
        chk("done_pulse", done, 32'(1) << wn);
        chk("done_en", reg_en, 0);
        @(posedge clk); #1;
        chk("post_done", done, 0);
        chk("rdata", rdata, reg_m);
        chk("post_regin", reg_in, rin_m);
        ptr_m = (wn + 1) % 4;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        txn(4'b0001, 4'b0001, 32'h000000A5, 0, 0);

        do_reset();
        txn(4'b0100, 4'b0000, 32'h0, 1, 0);
        txn(4'b0001, 4'b0000, 32'h0, 0, 0);

        do_reset();
        for (int i = 0; i < 5; i++) txn(4'b1111, 4'b0000, 32'h0, 0, 0);

        do_reset();
        txn(4'b0001, 4'b0001, 32'h0000003C, 0, 0);
        txn(4'b0100, 4'b0000, 32'h00FF0000, 0, 0);

        req = 4'b0001; we = 4'b0001; wdata = 32'h000000FF;
        @(posedge clk); #1;
        chk("mid_gnt1", gnt, 4'b0001);
        @(posedge clk); #1;
        chk("mid_en", reg_en, 1);
        chk("mid_regin", reg_in, 8'hFF);
        res = 1'b1; req = '0;
        @(posedge clk); #1;
        res = 1'b0;
        ptr_m = 0; rin_m = '0; reg_m = 8'hFF;
        chk("mid_rst_en", reg_en, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_rdata", rdata, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_no_done", done, 0);
        end
        txn(4'b0011, 4'b0000, 32'h0, 0, 0);

        for (int i = 0; i < 80; i++)
            txn(4'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 4) == 0), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
